// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-side definitions: datapath width, reset vector default,
// canonical NOP encoding and the instruction buffer entry layout.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a single-cycle flush; the head entry is shown
// combinationally and reads as zero while the FIFO is empty.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Flush wins over any push or pop presented in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// matching against an in-flight PC queue, and redirect handling with drop counting.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 2;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic [CW-1:0]   inflight_count;
  logic [CW-1:0]   buf_count;
  logic [CW-1:0]   drop_cnt;
  logic            inflight_empty;
  logic            buf_empty;
  fetch_entry_t    buf_head;
  fetch_entry_t    buf_push_entry;
  logic [OW-1:0]   occupancy;
  logic [OW-1:0]   drop_total;
  logic            req_fire;
  logic            rsp_accept;
  logic            rsp_drop;
  logic            if_pop;

  assign if_valid = !buf_empty && !redirect_valid;
  assign if_pop   = if_valid && if_ready;
  assign if_instr = buf_head.instr;
  assign if_pc    = buf_head.pc;

  // Requests still owed by memory (tracked or marked for dropping) plus buffered
  // instructions; an entry leaving the buffer this cycle frees its slot at once,
  // which is what sustains one instruction per cycle with DEPTH = 2.
  assign occupancy      = OW'(inflight_count) + OW'(drop_cnt) + OW'(buf_count) - OW'(if_pop);
  assign imem_req_valid = rst && !redirect_valid && (occupancy < OW'(DEPTH));
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop   = imem_rsp_valid && !redirect_valid && (drop_cnt != '0);
  assign rsp_accept = imem_rsp_valid && !redirect_valid && (drop_cnt == '0) && !inflight_empty;
  assign drop_total = OW'(inflight_count) + OW'(drop_cnt);
  assign buf_push_entry = '{pc: inflight_pc, instr: imem_rsp_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (req_fire) begin
      pc <= pc + XLEN'(4);
    end
  end

  // A redirect turns every request still owed by memory into a drop, except a
  // response landing in the redirect cycle itself, which is discarded directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      if (imem_rsp_valid && (drop_total != '0)) drop_cnt <= CW'(drop_total - OW'(1));
      else                                      drop_cnt <= CW'(drop_total);
    end else if (rsp_drop) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_inflight_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (pc),
    .pop       (rsp_accept),
    .head      (inflight_pc),
    .empty     (inflight_empty),
    .count     (inflight_count)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_accept),
    .push_data (buf_push_entry),
    .pop       (if_pop),
    .head      (buf_head),
    .empty     (buf_empty),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order fixed-latency memory model drives
// responses, and each scenario task compares outputs against hand-derived values.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int lat      = 1;

  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] hs_addr_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_instr_q[$];
  int          pop_cyc_q[$];
  logic        s_req_valid;
  logic        s_if_valid;

  fetch_unit #(
    .RESET_PC (RPC),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic int count_below(input logic [31:0] q[$], input logic [31:0] lim);
    int n = 0;
    foreach (q[i]) if (q[i] < lim) n++;
    return n;
  endfunction

  task automatic clear_model();
    mem_addr_q.delete();
    mem_due_q.delete();
    hs_addr_q.delete();
    pop_pc_q.delete();
    pop_instr_q.delete();
    pop_cyc_q.delete();
  endtask

  // One clock: present any due response, sample before the edge, log handshakes after it.
  task automatic tick();
    logic        hs;
    logic        pop;
    logic [31:0] a;
    logic [31:0] ppc;
    logic [31:0] pin;
    @(negedge clk);
    if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc + 1) begin
      a = mem_addr_q.pop_front();
      mem_due_q.delete(0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(a);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    assert (!(imem_rsp_valid && !redirect_valid && dut.inflight_count == '0 && dut.drop_cnt == '0))
      else $error("[TB] unsolicited response at cycle %0d", cyc);
    hs          = imem_req_valid && imem_req_ready;
    a           = imem_addr;
    pop         = if_valid && if_ready;
    ppc         = if_pc;
    pin         = if_instr;
    s_req_valid = imem_req_valid;
    s_if_valid  = if_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      mem_addr_q.push_back(a);
      mem_due_q.push_back(cyc + lat);
      hs_addr_q.push_back(a);
    end
    if (pop) begin
      pop_pc_q.push_back(ppc);
      pop_instr_q.push_back(pin);
      pop_cyc_q.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_req_valid: got %b, expected 0", imem_req_valid); end
    n_checks++; if (if_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_if_valid: got %b, expected 0", if_valid); end
    n_checks++; if (if_instr !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_if_instr: got %h, expected 0", if_instr); end
    n_checks++; if (if_pc !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_if_pc: got %h, expected 0", if_pc); end
    n_checks++; if (imem_addr !== RPC) begin n_fails++; $display("[TB] FAIL reset_addr: got %h, expected %h", imem_addr, RPC); end
    clear_model();
    rst = 1'b1;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL release_req_valid: got %b, expected 1", imem_req_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1;
    repeat (8) tick();
    n_checks++; if (pop_pc_q.size() != 6) begin n_fails++; $display("[TB] FAIL stream_pops: got %0d, expected 6", pop_pc_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (q_at(pop_pc_q, i) !== 32'(4 * i)) begin
        n_fails++; $display("[TB] FAIL stream_pc%0d: got %h, expected %h", i, q_at(pop_pc_q, i), 32'(4 * i));
      end
    end
    n_checks++;
    if (pop_cyc_q.size() < 3 || pop_cyc_q[1] != pop_cyc_q[0] + 1 || pop_cyc_q[2] != pop_cyc_q[1] + 1) begin
      n_fails++; $display("[TB] FAIL stream_rate: got %0d pops with gaps, expected one per cycle", pop_cyc_q.size());
    end
    n_checks++; if (q_at(pop_instr_q, 0) !== instr_of(32'h0)) begin n_fails++; $display("[TB] FAIL stream_instr0: got %h, expected %h", q_at(pop_instr_q, 0), instr_of(32'h0)); end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat = 1;
    if_ready = 1'b0;
    repeat (6) tick();
    n_checks++; if (hs_addr_q.size() != 2) begin n_fails++; $display("[TB] FAIL bp_requests: got %0d, expected 2", hs_addr_q.size()); end
    n_checks++; if (s_req_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL bp_req_valid: got %b, expected 0", s_req_valid); end
    n_checks++; if (s_if_valid !== 1'b1 || if_pc !== 32'h0) begin n_fails++; $display("[TB] FAIL bp_head: got valid %b pc %h, expected 1 / 0", s_if_valid, if_pc); end
    if_ready = 1'b1;
    tick();
    n_checks++; if (q_at(hs_addr_q, 2) !== 32'h8) begin n_fails++; $display("[TB] FAIL bp_resume_addr: got %h, expected 8", q_at(hs_addr_q, 2)); end
    n_checks++; if (if_pc !== 32'h4) begin n_fails++; $display("[TB] FAIL bp_next_head: got %h, expected 4", if_pc); end
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 3;
    repeat (2) tick();
    n_checks++; if (hs_addr_q.size() != 2) begin n_fails++; $display("[TB] FAIL redir_outstanding: got %0d, expected 2", hs_addr_q.size()); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (s_req_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL redir_req_blocked: got %b, expected 0", s_req_valid); end
    n_checks++; if (imem_addr !== 32'h100) begin n_fails++; $display("[TB] FAIL redir_addr: got %h, expected 100", imem_addr); end
    n_checks++; if (dut.drop_cnt !== 2'd2) begin n_fails++; $display("[TB] FAIL redir_drop_cnt: got %0d, expected 2", dut.drop_cnt); end
    repeat (10) tick();
    n_checks++; if (q_at(hs_addr_q, 2) !== 32'h100) begin n_fails++; $display("[TB] FAIL redir_first_req: got %h, expected 100", q_at(hs_addr_q, 2)); end
    n_checks++; if (q_at(pop_pc_q, 0) !== 32'h100) begin n_fails++; $display("[TB] FAIL redir_first_pc: got %h, expected 100", q_at(pop_pc_q, 0)); end
    n_checks++; if (count_below(pop_pc_q, 32'h100) != 0) begin n_fails++; $display("[TB] FAIL redir_old_path: got %0d stale, expected 0", count_below(pop_pc_q, 32'h100)); end
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    lat = 2;
    repeat (2) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (dut.drop_cnt !== 2'd1) begin n_fails++; $display("[TB] FAIL coinc_drop_cnt: got %0d, expected 1", dut.drop_cnt); end
    n_checks++; if (s_if_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL coinc_if_valid: got %b, expected 0", s_if_valid); end
    repeat (8) tick();
    n_checks++; if (q_at(hs_addr_q, 2) !== 32'h200) begin n_fails++; $display("[TB] FAIL coinc_first_req: got %h, expected 200", q_at(hs_addr_q, 2)); end
    n_checks++; if (q_at(pop_pc_q, 0) !== 32'h200) begin n_fails++; $display("[TB] FAIL coinc_first_pc: got %h, expected 200", q_at(pop_pc_q, 0)); end
    n_checks++; if (count_below(pop_pc_q, 32'h200) != 0) begin n_fails++; $display("[TB] FAIL coinc_old_path: got %0d stale, expected 0", count_below(pop_pc_q, 32'h200)); end
  endtask

  task automatic test_wrap();
    do_reset();
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fails++; $display("[TB] FAIL wrap_aligned: got %h, expected fffffffc", imem_addr); end
    tick();
    n_checks++; if (imem_addr !== 32'h0) begin n_fails++; $display("[TB] FAIL wrap_addr: got %h, expected 0", imem_addr); end
    repeat (4) tick();
    n_checks++; if (q_at(pop_pc_q, 0) !== 32'hFFFF_FFFC || q_at(pop_pc_q, 1) !== 32'h0) begin
      n_fails++; $display("[TB] FAIL wrap_pcs: got %h %h, expected fffffffc 0", q_at(pop_pc_q, 0), q_at(pop_pc_q, 1));
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    lat = 3;
    repeat (2) tick();
    n_checks++; if (dut.inflight_count !== 2'd2) begin n_fails++; $display("[TB] FAIL mid_inflight: got %0d, expected 2", dut.inflight_count); end
    rst = 1'b0;
    #1;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_req_valid: got %b, expected 0", imem_req_valid); end
    n_checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
      n_fails++; $display("[TB] FAIL mid_if_outputs: got %b %h %h, expected 0 0 0", if_valid, if_pc, if_instr);
    end
    n_checks++; if (imem_addr !== RPC) begin n_fails++; $display("[TB] FAIL mid_addr: got %h, expected %h", imem_addr, RPC); end
    n_checks++; if (dut.drop_cnt !== 2'd0) begin n_fails++; $display("[TB] FAIL mid_drop_cnt: got %0d, expected 0", dut.drop_cnt); end
    imem_rsp_valid = 1'b0;
    clear_model();
    lat = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) tick();
    n_checks++; if (q_at(hs_addr_q, 0) !== RPC) begin n_fails++; $display("[TB] FAIL mid_restart_addr: got %h, expected %h", q_at(hs_addr_q, 0), RPC); end
    n_checks++; if (q_at(pop_pc_q, 0) !== RPC) begin n_fails++; $display("[TB] FAIL mid_restart_pc: got %h, expected %h", q_at(pop_pc_q, 0), RPC); end
  endtask

  initial begin
    rst            = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_coincident();
    test_wrap();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
